// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: orders memory wait over
// load-use over branch flush, watches for hung data accesses, and counts stalls/flushes.
module hazard_ctrl #(
   parameter int REG_W       = 5,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             idex_memread_i,
   input  logic [REG_W-1:0] idex_rd_i,
   input  logic [REG_W-1:0] ifid_rs1_i,
   input  logic [REG_W-1:0] ifid_rs2_i,
   input  logic             ifid_use_rs2_i,
   input  logic             branch_taken_i,
   input  logic             dmem_req_i,
   input  logic             dmem_ack_i,
   input  logic             cnt_clr_i,
   output logic             pc_write_o,
   output logic             if_stall_o,
   output logic             if_flush_o,
   output logic             idex_bubble_o,
   output logic             freeze_o,
   output logic             mem_err_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] WAIT_FULL = WAIT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RUN      = 2'd1,
      S_MEM_WAIT = 2'd2,
      S_ERROR    = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              mem_err_q, mem_err_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic lu;
   logic mw;
   logic stall_inc;

   // A load targeting x0 never produces a value, so it can never hazard.
   assign lu = idex_memread_i && (idex_rd_i != '0) &&
               ((idex_rd_i == ifid_rs1_i) || (ifid_use_rs2_i && (idex_rd_i == ifid_rs2_i)));
   assign mw = dmem_req_i && !dmem_ack_i;

   // Pipeline controls. A branch seen under lu or mw is simply not flushed:
   // ID is held, so the branch re-resolves next cycle and nothing is latched.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      pc_write_o    = 1'b0;
      if_stall_o    = 1'b1;
      if_flush_o    = 1'b0;
      idex_bubble_o = 1'b1;
      freeze_o      = 1'b0;
      unique case (state_q)
         S_RUN: begin
            if (mw) begin
               freeze_o      = 1'b1;
               idex_bubble_o = 1'b0;
            end else if (lu) begin
               // IDLE defaults already describe a load-use stall.
            end else if (branch_taken_i) begin
               pc_write_o    = 1'b1;
               if_stall_o    = 1'b0;
               if_flush_o    = 1'b1;
               idex_bubble_o = 1'b0;
            end else begin
               pc_write_o    = 1'b1;
               if_stall_o    = 1'b0;
               idex_bubble_o = 1'b0;
            end
         end
         S_MEM_WAIT: begin
            freeze_o      = 1'b1;
            idex_bubble_o = 1'b0;
         end
         S_ERROR: begin
            freeze_o = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      mem_err_d = mem_err_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_RUN;
         end
         S_RUN: begin
            if (!start_i) begin
               state_d = S_IDLE;
               wait_d  = '0;
            end else if (mw) begin
               state_d = S_MEM_WAIT;
               wait_d  = WAIT_W'(1);
            end
         end
         S_MEM_WAIT: begin
            if (!start_i) begin
               state_d = S_IDLE;
               wait_d  = '0;
            end else if (dmem_ack_i) begin
               state_d = S_RUN;
               wait_d  = '0;
            end else if (wait_q == WAIT_LAST) begin
               // This cycle makes MEM_TIMEOUT consecutive cycles without an ack.
               state_d   = S_ERROR;
               wait_d    = WAIT_FULL;
               mem_err_d = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_ERROR: begin
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign stall_inc = ((state_q == S_RUN) || (state_q == S_MEM_WAIT)) && !pc_write_o;

   // Saturating counters; a clear beats a same-cycle increment.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (cnt_clr_i) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (stall_inc && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
         if (if_flush_o && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wait_q      <= '0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         wait_q      <= wait_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign mem_err_o   = mem_err_q;
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and stall controller for the 5-stage pipelined CPU.
- Drives the IF/ID register's stall/flush controls, the PC write enable, the ID/EX bubble insert and a global freeze for data-memory wait states.
- Prioritises memory wait over load-use over branch flush.
- Keeps a memory-wait watchdog and saturating stall/flush performance counters.

Parameters:
- REG_W, 5, register-index width.
- CNT_W, 16, performance counter width.
- MEM_TIMEOUT, 64, maximum consecutive wait cycles before mem_err.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  level; pipeline runs only while high.
- idex_memread_i  in  1  instruction in EX is a load.
- idex_rd_i  in  REG_W  destination of the instruction in EX.
- ifid_rs1_i  in  REG_W  rs1 of the instruction in ID.
- ifid_rs2_i  in  REG_W  rs2 of the instruction in ID.
- ifid_use_rs2_i  in  1  ID instruction reads rs2.
- branch_taken_i  in  1  ID resolved a taken branch or jump.
- dmem_req_i  in  1  MEM stage issues a data access.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- cnt_clr_i  in  1  synchronous clear of both counters.
- pc_write_o  out  1  PC register update enable.
- if_stall_o  out  1  IF/ID hold.
- if_flush_o  out  1  IF/ID load zero.
- idex_bubble_o  out  1  ID/EX loads NOP control.
- freeze_o  out  1  hold EX/MEM and MEM/WB.
- mem_err_o  out  1  sticky watchdog error.
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0 while running.
- flush_cnt_o  out  CNT_W  count of if_flush_o pulses.

Behaviour:
- State machine: IDLE, RUN, MEM_WAIT, ERROR. Reset state is IDLE.
- Reset: all registered outputs and counters are 0, wait counter is 0, mem_err_o=0.
- Combinational outputs while rst_n=0 equal the IDLE values.
- IDLE outputs: pc_write_o=0, if_stall_o=1, if_flush_o=0, idex_bubble_o=1, freeze_o=0.
- IDLE -> RUN on the clk edge with start_i=1.
- RUN or MEM_WAIT -> IDLE on any edge with start_i=0. The wait counter clears. This transition has priority over all others except reset.
- Load-use hazard (lu):
  - Condition: idex_memread_i & (idex_rd_i != 0) & (idex_rd_i == ifid_rs1_i | (ifid_use_rs2_i & idex_rd_i == ifid_rs2_i)).
  - A destination of x0 never hazards.
- Memory wait (mw): dmem_req_i & ~dmem_ack_i.
- RUN outputs, combinational, same cycle, first match wins:
  - mw: freeze_o=1, pc_write_o=0, if_stall_o=1, idex_bubble_o=0, if_flush_o=0.
  - lu: pc_write_o=0, if_stall_o=1, idex_bubble_o=1, if_flush_o=0.
  - branch_taken_i: pc_write_o=1, if_flush_o=1, if_stall_o=0, idex_bubble_o=0.
  - Otherwise: pc_write_o=1, all other controls 0.
- Branch deferral: a branch under lu or mw is not flushed that cycle. ID is held, so it re-resolves next cycle. No flush is latched.
- RUN -> MEM_WAIT on an edge with mw=1. The wait counter is set to 1.
- MEM_WAIT:
  - Outputs are the mw row unconditionally, ignoring lu and branch.
  - On dmem_ack_i=1 the outputs are still the mw row for that cycle. The state returns to RUN at the edge and the wait counter clears.
  - While dmem_ack_i=0 the wait counter increments.
  - If the counter reaches MEM_TIMEOUT with no ack, go to ERROR and set mem_err_o=1.
- ERROR:
  - Outputs equal IDLE except freeze_o=1.
  - mem_err_o stays set until reset.
  - start_i has no effect.
- Counters:
  - stall_cnt_o increments on each edge where the state is RUN or MEM_WAIT and pc_write_o=0.
  - flush_cnt_o increments on each edge where if_flush_o=1.
  - Both saturate at all-ones.
  - cnt_clr_i wins over an increment in the same cycle.
- Reset mid-MEM_WAIT: immediate return to IDLE and all registers clear.
- The block holds no instruction data; only control.

Test Plan:
- Reset, then start_i=1, no hazards -> from the cycle after the start edge: pc_write_o=1 every cycle, stall_cnt_o=0, flush_cnt_o=0.
- idex_memread_i=1, idex_rd_i=5, ifid_rs1_i=5 for 1 cycle -> same cycle pc_write_o=0, if_stall_o=1, idex_bubble_o=1; stall_cnt_o=1. Repeat with idex_rd_i=0 -> no stall.
- branch_taken_i=1 alone -> if_flush_o=1, pc_write_o=1 for one cycle; flush_cnt_o=1. Branch coincident with lu -> if_flush_o=0, pc_write_o=0, then flush next cycle once lu drops.
- dmem_req_i=1 with ack after 3 cycles -> freeze_o=1 for 4 cycles including the ack cycle, state returns to RUN, stall_cnt_o=4; lu asserted during the wait produces no bubble.
- dmem_req_i=1 and no ack for MEM_TIMEOUT=64 cycles -> ERROR state, mem_err_o=1, freeze_o=1; start_i toggling has no effect; rst_n low clears to IDLE.
- Force the counter to all-ones -> further stall cycles hold the value; cnt_clr_i together with an increment -> 0.
